// File: rtl/per_pkg.sv
// Shared types and helpers for the peripheral receiver slice.
package per_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;

    // Width needed to hold an occupancy value from 0 up to and including depth.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/peripheral_receiver_if.sv
// Send/ack channel from the processor plus the valid/ready drain port.
interface peripheral_receiver_if
    import per_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
);
    logic                       insend;
    logic [DATA_W-1:0]          indata;
    logic                       ack;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [count_w(DEPTH)-1:0]  fifo_count;
    logic [CNT_W-1:0]           rx_count;

    // Processor and local consumer side.
    modport master (
        output insend, indata, out_ready,
        input  ack, out_data, out_valid, fifo_count, rx_count
    );

    // Receiver side.
    modport slave (
        input  insend, indata, out_ready,
        output ack, out_data, out_valid, fifo_count, rx_count
    );
endinterface

// File: rtl/per_fifo.sv
// Small circular FIFO with occupancy count; head is shown combinationally.
module per_fifo
    import per_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = count_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Empty FIFO shows zero so the head is defined without resetting storage.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/peripheral_receiver.sv
// Peripheral receiver: 4-phase send/ack sink feeding a local FIFO.
// Optional macro PER_SYNC_EN inserts a 2-flop synchronizer on insend;
// without it insend is used directly for same-clock integration.
module peripheral_receiver
    import per_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clkPER,
    input  logic                 rst,
    peripheral_receiver_if.slave bus
);
    localparam int CW = count_w(DEPTH);

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [CNT_W-1:0]   rx_count_q, rx_count_d;
    logic               send_s;
    logic               wr_en;
    logic               fifo_full, fifo_empty;
    logic [DATA_W-1:0]  fifo_rd_data;
    logic [CW-1:0]      fifo_cnt;

`ifdef PER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer bringing insend into the clkPER domain.
    always_ff @(posedge clkPER) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], bus.insend};
    end

    assign send_s = sync_q[1];
`else
    assign send_s = bus.insend;
`endif

    // Handshake FSM: one write per send pulse, ack held until send drops.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        rx_count_d = rx_count_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (send_s && !fifo_full) begin
                    wr_en      = 1'b1;
                    rx_count_d = rx_count_q + CNT_W'(1);
                    ack_d      = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                ack_d = 1'b1;
                if (!send_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, ack and received-word counter registers.
    always_ff @(posedge clkPER) begin
        if (!rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rx_count_q <= rx_count_d;
        end
    end

    per_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clkPER),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (bus.indata),
        .rd_en   (bus.out_ready & ~fifo_empty),
        .rd_data (fifo_rd_data),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.ack        = ack_q;
    assign bus.out_data   = fifo_rd_data;
    assign bus.out_valid  = ~fifo_empty;
    assign bus.fifo_count = fifo_cnt;
    assign bus.rx_count   = rx_count_q;

endmodule

// File: tb/tb_peripheral_receiver.sv
// Directed self-checking bench for peripheral_receiver with a word scoreboard.
module tb_peripheral_receiver;
    import per_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
`ifdef PER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clkPER = 1'b0;
    logic rst;

    peripheral_receiver_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    peripheral_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clkPER (clkPER),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clkPER = ~clkPER;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb [$];
    int exp_rx = 0;

    task automatic tick();
        @(posedge clkPER);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits a bounded number of cycles for ack to reach v; a timeout shows as a failed check.
    task automatic wait_ack(input string tag, input logic v, input int budget);
        int n = 0;
        while (bus.ack !== v && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus.ack}, {31'd0, v});
    endtask

    task automatic handshake(input logic [DATA_W-1:0] v);
        bus.indata = v;
        bus.insend = 1'b1;
        wait_ack("hs_ack_hi", 1'b1, 10);
        sb.push_back(v);
        exp_rx++;
        bus.insend = 1'b0;
        wait_ack("hs_ack_lo", 1'b0, 10);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W-1:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 16'hDEAD;
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check(tag, {16'd0, bus.out_data}, {16'd0, e});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.insend    = 1'b1;
        bus.indata    = 16'hAAAA;
        bus.out_ready = 1'b0;

        // Reset held with insend high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ack", {31'd0, bus.ack}, 32'd0);
            check("rst_fifo_count", {29'd0, bus.fifo_count}, 32'd0);
            check("rst_rx_count", {16'd0, bus.rx_count}, 32'd0);
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        end
        bus.insend = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("idle_ack", {31'd0, bus.ack}, 32'd0);

        // Single transfer with exact latency.
        bus.indata = 16'd2;
        bus.insend = 1'b1;
        repeat (LAT - 1) tick();
        check("single_ack_early", {31'd0, bus.ack}, 32'd0);
        tick();
        check("single_ack", {31'd0, bus.ack}, 32'd1);
        check("single_count", {29'd0, bus.fifo_count}, 32'd1);
        sb.push_back(16'd2);
        exp_rx++;
        bus.insend = 1'b0;
        repeat (LAT - 1) tick();
        check("single_ack_hold", {31'd0, bus.ack}, 32'd1);
        tick();
        check("single_ack_low", {31'd0, bus.ack}, 32'd0);
        check("single_rx", {16'd0, bus.rx_count}, exp_rx);
        pop_check("single_data");
        check("single_drained", {29'd0, bus.fifo_count}, 32'd0);

        // Long pulse gives exactly one write.
        bus.indata = 16'd7;
        bus.insend = 1'b1;
        repeat (20) tick();
        check("long_ack", {31'd0, bus.ack}, 32'd1);
        check("long_count", {29'd0, bus.fifo_count}, 32'd1);
        sb.push_back(16'd7);
        exp_rx++;
        check("long_rx", {16'd0, bus.rx_count}, exp_rx);
        bus.insend = 1'b0;
        repeat (LAT) tick();
        check("long_ack_low", {31'd0, bus.ack}, 32'd0);
        pop_check("long_data");

        // Back-pressure: fill, then a fifth request is withheld.
        for (int v = 1; v <= 4; v++) handshake(16'(v));
        check("bp_full_count", {29'd0, bus.fifo_count}, 32'd4);
        bus.indata = 16'd5;
        bus.insend = 1'b1;
        repeat (6) tick();
        check("bp_held_ack", {31'd0, bus.ack}, 32'd0);
        check("bp_held_count", {29'd0, bus.fifo_count}, 32'd4);
        check("bp_held_rx", {16'd0, bus.rx_count}, exp_rx);
        pop_check("bp_pop1");
        wait_ack("bp_5_ack", 1'b1, 10);
        sb.push_back(16'd5);
        exp_rx++;
        bus.insend = 1'b0;
        wait_ack("bp_5_ack_low", 1'b0, 10);
        check("bp_refill_count", {29'd0, bus.fifo_count}, 32'd4);
        check("bp_rx", {16'd0, bus.rx_count}, exp_rx);
        pop_check("bp_pop2");
        pop_check("bp_pop3");
        check("bp_two_left", {29'd0, bus.fifo_count}, 32'd2);

        // Write and pop on the same edge.
        bus.indata = 16'd9;
        bus.insend = 1'b1;
        repeat (LAT - 1) tick();
        check("simul_head", {16'd0, bus.out_data}, {16'd0, sb[0]});
        void'(sb.pop_front());
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("simul_ack", {31'd0, bus.ack}, 32'd1);
        check("simul_count", {29'd0, bus.fifo_count}, 32'd2);
        sb.push_back(16'd9);
        exp_rx++;
        bus.insend = 1'b0;
        wait_ack("simul_ack_low", 1'b0, 10);
        pop_check("simul_pop_a");
        pop_check("simul_pop_b");
        check("simul_empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset while in HOLD with insend still high, then re-accept.
        bus.indata = 16'h1234;
        bus.insend = 1'b1;
        wait_ack("mid_ack_hi", 1'b1, 10);
        rst = 1'b0;
        tick();
        check("mid_rst_ack", {31'd0, bus.ack}, 32'd0);
        check("mid_rst_count", {29'd0, bus.fifo_count}, 32'd0);
        check("mid_rst_rx", {16'd0, bus.rx_count}, 32'd0);
        sb.delete();
        exp_rx = 0;
        rst = 1'b1;
        wait_ack("mid_reaccept_ack", 1'b1, 10);
        sb.push_back(16'h1234);
        exp_rx++;
        check("mid_reaccept_rx", {16'd0, bus.rx_count}, exp_rx);
        check("mid_reaccept_count", {29'd0, bus.fifo_count}, 32'd1);
        bus.insend = 1'b0;
        wait_ack("mid_ack_low", 1'b0, 10);
        pop_check("mid_data");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
